load_store_unit: RTL
====================

# load_store_unit

Sits between the core's execute stage and the byte-addressed data memory. Accepts one load or store request at a time, checks alignment and range, performs sub-word read-modify-write for SB/SH, and extracts and sign- or zero-extends load data. It returns a single-cycle response pulse. The core holds its request stable while `req_ready` is low.

## Interface

Parameters:
- `MEM_BYTES`, 128: size of the data memory in bytes. Valid byte addresses are 0..MEM_BYTES-1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: reset, synchronous and active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit can accept a request. High only in IDLE.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RISC-V width code (loads 000/001/010/100/101, stores 000/001/010).
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `resp_valid`  out  1: one-cycle response pulse.
- `resp_rdata`  out  32: formatted load data. 0 for stores and errors.
- `resp_error`  out  1: misaligned, out-of-range or illegal funct3.
- `mem_read_address`  out  32: memory read address. The memory read is combinational.
- `mem_read_data`  in  32: little-endian bytes [addr..addr+3].
- `mem_write_address`  out  32: memory write address.
- `mem_write_en`  out  1: memory writes 4 bytes at the next rising edge.
- `mem_write_data`  out  32: full word to write.

## Operation

FSM states are IDLE, ACCESS, WRITE and RESP.

- **IDLE**
  - A handshake occurs when `req_valid && req_ready`.
  - On handshake, latch `we`, `funct3`, `addr` and `wdata` into `_q` registers.
- **Error check** (computed at acceptance)
  - Size is 1/2/4 bytes for funct3[1:0] = 00/01/10.
  - Misaligned: halfword with addr[0] != 0, or word with addr[1:0] != 0.
  - Out of range: addr + size > MEM_BYTES. Compute the sum 33-bit wide so it cannot wrap.
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - Any error goes IDLE->RESP with `resp_error=1`. No memory write is issued.
- **Load**
  - IDLE->ACCESS: drive `mem_read_address=addr_q`.
  - In ACCESS, register the formatted data into `rdata_q`:
    - LB: sign-extend [7:0].
    - LBU: zero-extend [7:0].
    - LH: sign-extend [15:0].
    - LHU: zero-extend [15:0].
    - LW: [31:0].
  - ACCESS->RESP.
- **SW**
  - IDLE->WRITE: `mem_write_en=1`, address `addr_q`, data `wdata_q`.
  - WRITE->RESP.
- **SB/SH**
  - IDLE->ACCESS: read the word at `addr_q`.
  - In ACCESS, register the merge:
    - SB: {old[31:8], wdata_q[7:0]}.
    - SH: {old[31:16], wdata_q[15:0]}.
  - ACCESS->WRITE->RESP. The merge is required because the memory always writes 4 bytes.
- **RESP**
  - `resp_valid=1` for exactly one cycle, then RESP->IDLE.
  - No backpressure on the response.
- `mem_write_en` is high only in WRITE.
- `mem_read_address` equals `addr_q` in every state.
- `mem_write_address` equals `addr_q` in every state.

## Timing

Cycle N is the rising edge at which the request is accepted.

- `resp_valid` latency:
  - Error: high during cycle N+1.
  - Load: high during N+2.
  - SW: high during N+2; the write commits at the edge ending N+1.
  - SB/SH: high during N+3; the write commits at the edge ending N+2.
- `req_ready` rises in the cycle after RESP. Back-to-back requests therefore have one idle cycle of turnaround.
- `resp_rdata` and `resp_error` are valid only while `resp_valid` is high. Otherwise they are 0.
- Reset:
  - State goes to IDLE and all `_q` registers clear.
  - `req_ready=0` while `reset` is high.
  - `resp_valid`, `resp_error`, `resp_rdata`, `mem_write_en` and `mem_write_data` are all 0.
- Reset mid-operation aborts the transaction:
  - No `mem_write_en` in the reset cycle or afterwards.
  - No response is produced.
  - Reset in WRITE suppresses that write.
- A request presented during reset is not accepted.

## Structure

- Package `lsu_pkg` holds:
  - the funct3 localparams `F3_B=3'b000`, `F3_H=3'b001`, `F3_W=3'b010`, `F3_BU=3'b100`, `F3_HU=3'b101`;
  - `typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_t`.
- Sub-module `lsu_format` (combinational) provides load extraction with extension, and store merge.
- The FSM, error check and registers live in `load_store_unit`.

## Test plan

Bench memory model preloads bytes 0..3 = AA,81,0F,F0, so word@0 = 0xF00F81AA.

- LB addr 1 -> `resp_rdata`=0xFFFFFF81 at N+2. LBU addr 1 -> 0x00000081. LH addr 2 -> 0xFFFFF00F.
- SB addr 0, wdata 0x12345655:
  - `mem_write_en` high only in N+2, with `mem_write_data`=0xF00F8155.
  - Response at N+3.
  - A subsequent LW addr 0 returns 0xF00F8155.
- SW addr 124, wdata 0xDEADBEEF -> single write at N+1, response at N+2. LW addr 124 then returns 0xDEADBEEF.
- Error cases, each giving `resp_error=1` at N+1 with zero `mem_write_en` pulses:
  - SH addr 1 (misaligned);
  - LW addr 126 (out of range, 126+4>128);
  - load funct3=011 (illegal).
- Reset during an SB at state WRITE -> no write, no response, `req_ready`=0. Memory byte 0 still reads 0xAA afterwards.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: RISC-V width codes,
// FSM state encoding and the request legality checks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_t;

    // Access size in bytes from funct3[1:0]; the reserved 11 code is
    // rejected by funct3_legal, so its size only has to be harmless.
    function automatic logic [2:0] access_size(input logic [1:0] width);
        case (width)
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we)
            funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                           (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr_lsb);
        case (width)
            2'b01:   misaligned = addr_lsb[0];
            2'b10:   misaligned = |addr_lsb;
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_format.sv
// Combinational data formatting: load extraction with sign/zero extension
// and the sub-word merge used for SB/SH read-modify-write.
module lsu_format
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    always_comb begin
        load_data = mem_word;
        case (funct3)
            F3_B:    load_data = {{24{mem_word[7]}}, mem_word[7:0]};
            F3_BU:   load_data = {24'd0, mem_word[7:0]};
            F3_H:    load_data = {{16{mem_word[15]}}, mem_word[15:0]};
            F3_HU:   load_data = {16'd0, mem_word[15:0]};
            default: load_data = mem_word;
        endcase
    end

    // Memory always writes a full word, so narrow stores keep the old upper bytes.
    always_comb begin
        merge_data = store_data;
        case (funct3)
            F3_B:    merge_data = {mem_word[31:8], store_data[7:0]};
            F3_H:    merge_data = {mem_word[31:16], store_data[15:0]};
            default: merge_data = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a byte-addressed data memory:
// one request at a time, alignment/range checks, sub-word RMW, one-cycle response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_write_address,
    output logic        mem_write_en,
    output logic [31:0] mem_write_data,
    output lsu_state_t  dbg_state
);

    lsu_state_t  state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [32:0] end_addr;
    logic        req_error;
    logic        accept;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    // req_ready is high only in IDLE outside reset; the core holds the request
    // stable until then. The response has no ready and is never stalled.
    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // 33-bit end address so requests near 2^32 cannot wrap back into range.
    always_comb begin
        end_addr  = {1'b0, req_addr} + {30'd0, access_size(req_funct3[1:0])};
        req_error = !funct3_legal(req_we, req_funct3) ||
                    misaligned(req_funct3[1:0], req_addr[1:0]) ||
                    (end_addr > 33'(MEM_BYTES));
    end

    lsu_format u_format (
        .funct3     (funct3_q),
        .mem_word   (mem_read_data),
        .store_data (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rdata_q  <= 32'd0;
                        err_q    <= req_error;
                        if (req_error)
                            state <= RESP;
                        else if (req_we && (req_funct3 == F3_W))
                            state <= WRITE;
                        else
                            state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        wdata_q <= merge_data;
                        state   <= WRITE;
                    end else begin
                        rdata_q <= load_data;
                        state   <= RESP;
                    end
                end
                WRITE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are gated by reset so an aborted transaction never writes or responds.
    assign resp_valid        = (state == RESP) && !reset;
    assign resp_rdata        = resp_valid ? rdata_q : 32'd0;
    assign resp_error        = resp_valid && err_q;
    assign mem_write_en      = (state == WRITE) && !reset;
    assign mem_write_data    = reset ? 32'd0 : wdata_q;
    assign mem_read_address  = addr_q;
    assign mem_write_address = addr_q;
    assign dbg_state         = state;

endmodule
